// File: rtl/mult_parity_seq.sv
// Sequential signed multiplier (shift-add, one multiplier bit per cycle) with
// even-parity checking on both operands and a req/ack + result_rdy handshake.
module mult_parity_seq #(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic [DATA_W-1:0]   arg_a,
    input  logic                arg_a_parity,
    input  logic [DATA_W-1:0]   arg_b,
    input  logic                arg_b_parity,
    output logic                ack,
    output logic [2*DATA_W-1:0] result,
    output logic                result_parity,
    output logic                arg_parity_error,
    output logic                result_rdy
);

    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} state_t;

    state_t             state_q, state_d;
    logic               armed_q, armed_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic               a_par_q, a_par_d, b_par_q, b_par_d;
    logic [DATA_W:0]    mcand_q, mcand_d, mplier_q, mplier_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               rpar_q, rpar_d;
    logic               perr_q, perr_d;

    logic               accept, perr, last_iter;
    logic [DATA_W:0]    a_ext, b_ext, a_abs, b_abs;
    logic [RES_W-1:0]   mcand_ext, partial, acc_sum, signed_res;

    assign accept    = (state_q == IDLE) && req && armed_q;
    assign perr      = (a_par_q != ^a_q) | (b_par_q != ^b_q);
    assign last_iter = (cnt_q == CNT_LAST);

    // Magnitudes are one bit wider so that |-2^(W-1)| is representable.
    assign a_ext = {a_q[DATA_W-1], a_q};
    assign b_ext = {b_q[DATA_W-1], b_q};
    assign a_abs = a_ext[DATA_W] ? -a_ext : a_ext;
    assign b_abs = b_ext[DATA_W] ? -b_ext : b_ext;

    assign mcand_ext  = {{(RES_W-DATA_W-1){1'b0}}, mcand_q};
    assign partial    = mplier_q[0] ? (mcand_ext << cnt_q) : '0;
    assign acc_sum    = acc_q + partial;
    assign signed_res = sign_q ? -acc_sum : acc_sum;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)    state_d = LOAD;
            LOAD: state_d = perr ? DONE : MUL;
            MUL:  if (last_iter) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        ack        = (state_q == LOAD);
        result_rdy = (state_q == DONE);
    end

    // Datapath next values
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        a_par_d  = a_par_q;
        b_par_d  = b_par_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        result_d = result_q;
        rpar_d   = rpar_q;
        perr_d   = perr_q;
        // A held req must drop for at least one edge before it can re-trigger.
        armed_d  = accept ? 1'b0 : (!req ? 1'b1 : armed_q);

        if (accept) begin
            a_d     = arg_a;
            b_d     = arg_b;
            a_par_d = arg_a_parity;
            b_par_d = arg_b_parity;
        end

        case (state_q)
            LOAD: begin
                if (perr) begin
                    result_d = '0;
                    rpar_d   = 1'b0;
                    perr_d   = 1'b1;
                end else begin
                    mcand_d  = a_abs;
                    mplier_d = b_abs;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sign_d   = a_q[DATA_W-1] ^ b_q[DATA_W-1];
                end
            end
            MUL: begin
                acc_d    = acc_sum;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    result_d = signed_res;
                    rpar_d   = ^signed_res;
                    perr_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed_q  <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            a_par_q  <= 1'b0;
            b_par_q  <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            rpar_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            armed_q  <= armed_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_par_q  <= a_par_d;
            b_par_q  <= b_par_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            rpar_q   <= rpar_d;
            perr_q   <= perr_d;
        end
    end

    assign result           = result_q;
    assign result_parity    = rpar_q;
    assign arg_parity_error = perr_q;

endmodule

// File: tb/tb_mult_parity_seq.sv
// Directed bench for mult_parity_seq: expected results are queued at launch
// and compared by a monitor whenever result_rdy strobes.
module tb_mult_parity_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [15:0] arg_a = '0, arg_b = '0;
    logic        arg_a_parity = 1'b0, arg_b_parity = 1'b0;
    logic        ack, result_parity, arg_parity_error, result_rdy;
    logic [31:0] result;

    typedef struct packed {
        logic [31:0] res;
        logic        par;
        logic        perr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_total = 0;

    mult_parity_seq #(.DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .arg_a(arg_a), .arg_a_parity(arg_a_parity),
        .arg_b(arg_b), .arg_b_parity(arg_b_parity),
        .ack(ack), .result(result), .result_parity(result_parity),
        .arg_parity_error(arg_parity_error), .result_rdy(result_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Result monitor, sampled just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (ack || result_rdy) chk("ack_rdy_exclusive", 64'(ack & result_rdy), 64'd0);
        if (result_rdy) begin
            rdy_total++;
            chk("rdy_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("result_parity", 64'(result_parity), 64'(e.par));
                chk("arg_parity_error", 64'(arg_parity_error), 64'(e.perr));
            end
        end
    end

    // Drive operands and req; optionally queue the expected outcome.
    task automatic launch(input logic signed [15:0] a, input logic signed [15:0] b,
                          input logic pa, input logic pb, input bit push);
        exp_t e;
        logic signed [31:0] p;
        arg_a = a; arg_b = b; arg_a_parity = pa; arg_b_parity = pb;
        req = 1'b1;
        p = a * b;
        e.perr = (pa != ^a) | (pb != ^b);
        e.res  = e.perr ? 32'd0 : p;
        e.par  = e.perr ? 1'b0 : ^p;
        if (push) exp_q.push_back(e);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!ack && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk("ack_seen", 64'(ack), 64'd1);
    endtask

    // Called in the ack cycle: release req and measure ack->result_rdy latency.
    task automatic finish_op(input int exp_lat);
        int lat = 0;
        req = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!result_rdy && lat < 40);
        chk("latency", 64'(lat), 64'(exp_lat));
        @(negedge clk);
    endtask

    task automatic run_op(input logic signed [15:0] a, input logic signed [15:0] b,
                          input logic pa, input logic pb, input int exp_lat);
        @(negedge clk);
        launch(a, b, pa, pb, 1'b1);
        @(negedge clk);
        wait_ack();
        finish_op(exp_lat);
    endtask

    initial begin
        int acks, rdys, rdy_before;

        // Reset held with req high: nothing may happen.
        launch(16'sd3, -16'sd5, ^16'sd3, ^(-16'sd5), 1'b1);
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("reset_no_ack", 64'(acks), 64'd0);
        chk("reset_rdy", 64'(result_rdy), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_rpar", 64'(result_parity), 64'd0);
        chk("reset_perr", 64'(arg_parity_error), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ack_after_release", 64'(ack), 64'd1);
        finish_op(17);

        // Corner operands and parity error.
        run_op(-16'sd32768, -16'sd32768, ^16'h8000, ^16'h8000, 17);
        run_op(16'sd0, 16'sd12345, 1'b0, ^16'sd12345, 17);
        run_op(-16'sd32768, 16'sd32767, ^16'h8000, ^16'h7fff, 17);
        run_op(16'sd7, 16'sd2, 1'b0, ^16'sd2, 1);
        run_op(-16'sd1234, 16'sd4321, ^(-16'sd1234), ^16'sd4321, 17);
        run_op(16'sd9, -16'sd9, ^16'sd9, 1'b0, 1);

        // req held for 40 cycles: exactly one operation.
        @(negedge clk);
        launch(16'sd5, 16'sd6, ^16'sd5, ^16'sd6, 1'b1);
        acks = 0; rdys = 0;
        repeat (40) begin
            @(negedge clk);
            if (ack) acks++;
            if (result_rdy) rdys++;
        end
        chk("held_req_acks", 64'(acks), 64'd1);
        chk("held_req_rdys", 64'(rdys), 64'd1);
        req = 1'b0;
        @(negedge clk);
        launch(16'sd11, 16'sd13, ^16'sd11, ^16'sd13, 1'b1);
        @(negedge clk);
        wait_ack();
        finish_op(17);

        // Reset during MUL aborts without a result strobe.
        rdy_before = rdy_total;
        @(negedge clk);
        launch(16'sd77, 16'sd99, ^16'sd77, ^16'sd99, 1'b0);
        @(negedge clk);
        wait_ack();
        req = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_rpar", 64'(result_parity), 64'd0);
        chk("abort_perr", 64'(arg_parity_error), 64'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_rdy", 64'(rdy_total), 64'(rdy_before));
        run_op(16'sd100, 16'sd100, ^16'sd100, ^16'sd100, 17);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
